uart_rx: RTL and testbench

- 8N1 UART receiver; counterpart of the team's uart_tx. Same clock domain and baud parameters.
- Deserialises the asynchronous serial line `rx` into bytes.
- Presents each good byte on `data` with a one-cycle `data_valid` strobe. Flags bad stop bits on `frame_err`.
- Sits between the board UART pin and the command/NEC-decode logic.

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Signal bundle between the UART pin side and the byte consumer of the 8N1 receiver.
// The receiver takes the master modport; the consumer/driver of the line takes slave.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rx,
        output data,
        output data_valid,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  data,
        input  data_valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, confirms the start bit at mid-bit, samples each data
// bit at mid-bit and reports a good byte (data_valid) or a low stop bit (frame_err).
module uart_rx #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 115_200
) (
    input  logic      sys_clk,
    input  logic      sys_rst_n,
    uart_rx_if.master rx_bus
);

    // CLKS_PER_BIT must be at least 8 so the mid-bit sample has margin after edge detection.
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);

    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(HALF_BIT - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            data_valid_q, data_valid_d;
    logic            frame_err_q, frame_err_d;

    logic rx_meta_q, rx_s_q, rx_d_q;
    logic fall_edge;

    // Synchroniser and history flop reset high so an idle line never looks like an edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_bus.rx;
            rx_s_q    <= rx_meta_q;
            rx_d_q    <= rx_s_q;
        end
    end

    assign fall_edge = rx_d_q & ~rx_s_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= StIdle;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q + CntOne;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                clk_cnt_d = '0;
                if (fall_edge) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (clk_cnt_q == CntHalf) begin
                    clk_cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = StData;
                        bit_idx_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (clk_cnt_q == CntLast) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (clk_cnt_q == CntLast) begin
                    clk_cnt_d = '0;
                    if (rx_s_q) begin
                        data_d       = shift_q;
                        data_valid_d = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitIdle;
                    end
                end
            end
            StWaitIdle: begin
                // Hold here through a break so a long low line reports only one error.
                clk_cnt_d = '0;
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                clk_cnt_d = '0;
                state_d   = StIdle;
            end
        endcase
    end

    assign rx_bus.data       = data_q;
    assign rx_bus.data_valid = data_valid_q;
    assign rx_bus.frame_err  = frame_err_q;
    assign rx_bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of single frames, hand-built corner sequences and a randomised
// stream compared against a byte-queue model of the line protocol.
module tb_uart_rx;

    localparam int unsigned ClkFreq = 2_000_000;
    localparam int unsigned Baud    = 100_000;
    localparam int          Cpb     = 20;
    localparam int          Half    = 10;
    localparam int          BitT    = 200;  // Cpb clocks of 10 time units

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_rx_if u_if ();

    uart_rx #(
        .CLK_FREQ (ClkFreq),
        .BAUD_RATE(Baud)
    ) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .rx_bus   (u_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Passive monitor, sampled on the falling clock edge.
    int         cyc         = 0;
    int         dv_cnt      = 0;
    int         fe_cnt      = 0;
    int         overlap_cnt = 0;
    int         wide_cnt    = 0;
    int         busy_dv_err = 0;
    int         busy_fe_err = 0;
    int         busy_rise   = 0;
    int         busy_len    = 0;
    logic       prev_dv     = 1'b0;
    logic       prev_fe     = 1'b0;
    logic       prev_busy   = 1'b0;
    logic [7:0] obs_q[$];
    int         dv_times[$];

    always @(negedge clk) begin
        cyc++;
        if (u_if.data_valid === 1'b1) begin
            dv_cnt++;
            obs_q.push_back(u_if.data);
            dv_times.push_back(cyc);
            busy_len = cyc - busy_rise;
            if (u_if.busy !== 1'b0) busy_dv_err++;
            if (prev_dv) wide_cnt++;
        end
        if (u_if.frame_err === 1'b1) begin
            fe_cnt++;
            if (u_if.busy !== 1'b1) busy_fe_err++;
            if (prev_fe) wide_cnt++;
        end
        if (u_if.data_valid === 1'b1 && u_if.frame_err === 1'b1) overlap_cnt++;
        if (u_if.busy === 1'b1 && !prev_busy) busy_rise = cyc;
        prev_dv   = (u_if.data_valid === 1'b1);
        prev_fe   = (u_if.frame_err === 1'b1);
        prev_busy = (u_if.busy === 1'b1);
    end

    // Leaves the line at the stop-bit level; callers decide when it returns high.
    task automatic send_frame(input logic [7:0] b, input int bit_t, input logic stop_v);
        u_if.rx = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            u_if.rx = b[i];
            #(bit_t);
        end
        u_if.rx = stop_v;
        #(bit_t);
    endtask

    typedef struct {
        logic [7:0] byte_v;
        int         bit_t;
        logic       stop_v;
        int         exp_dv;
        int         exp_fe;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       vecs[8];
    int         b0, f0, n0, fe_exp;
    logic [7:0] rb;
    logic [7:0] exp_q[$];
    int         bts[3];
    logic [7:0] a3;

    initial begin
        vecs[0] = '{8'hA3, 200, 1'b1, 1, 0, 8'hA3};
        vecs[1] = '{8'h3C, 200, 1'b0, 0, 1, 8'hA3};
        vecs[2] = '{8'h81, 200, 1'b1, 1, 0, 8'h81};
        vecs[3] = '{8'hA3, 196, 1'b1, 1, 0, 8'hA3};
        vecs[4] = '{8'h4B, 204, 1'b1, 1, 0, 8'h4B};
        vecs[5] = '{8'hA3, 204, 1'b1, 1, 0, 8'hA3};
        vecs[6] = '{8'hC6, 196, 1'b0, 0, 1, 8'hA3};
        vecs[7] = '{8'hFF, 200, 1'b1, 1, 0, 8'hFF};
        bts     = '{196, 200, 204};
        a3      = 8'hA3;

        u_if.rx = 1'b1;
        rst_n   = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_data", u_if.data, 8'h00);
        check("reset_dv", u_if.data_valid, 1'b0);
        check("reset_fe", u_if.frame_err, 1'b0);
        check("reset_busy", u_if.busy, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            b0 = dv_cnt;
            f0 = fe_cnt;
            send_frame(vecs[i].byte_v, vecs[i].bit_t, vecs[i].stop_v);
            u_if.rx = 1'b1;
            repeat (2 * Cpb) @(negedge clk);
            check($sformatf("vec%0d_dv", i), dv_cnt - b0, vecs[i].exp_dv);
            check($sformatf("vec%0d_fe", i), fe_cnt - f0, vecs[i].exp_fe);
            check($sformatf("vec%0d_data", i), u_if.data, vecs[i].exp_data);
            check($sformatf("vec%0d_busy", i), u_if.busy, 1'b0);
            if (i == 0) check("busy_len", busy_len, Half + 9 * Cpb);
        end

        // Back-to-back frames with no idle time between them.
        n0 = obs_q.size();
        send_frame(8'h55, BitT, 1'b1);
        send_frame(8'h00, BitT, 1'b1);
        send_frame(8'hFF, BitT, 1'b1);
        repeat (2 * Cpb) @(negedge clk);
        check("b2b_count", obs_q.size() - n0, 3);
        if (obs_q.size() >= n0 + 3) begin
            check("b2b_byte0", obs_q[n0], 8'h55);
            check("b2b_byte1", obs_q[n0+1], 8'h00);
            check("b2b_byte2", obs_q[n0+2], 8'hFF);
            check_range("b2b_gap0", dv_times[n0+1] - dv_times[n0], 10 * Cpb - 3, 10 * Cpb + 3);
            check_range("b2b_gap1", dv_times[n0+2] - dv_times[n0+1], 10 * Cpb - 3, 10 * Cpb + 3);
        end

        // Short low glitch: start is rejected at mid-bit.
        b0 = dv_cnt;
        f0 = fe_cnt;
        u_if.rx = 1'b0;
        repeat (5) @(negedge clk);
        u_if.rx = 1'b1;
        repeat (3) @(negedge clk);
        check("glitch_busy_hi", u_if.busy, 1'b1);
        repeat (Half + 5) @(negedge clk);
        check("glitch_busy_lo", u_if.busy, 1'b0);
        check("glitch_dv", dv_cnt - b0, 0);
        check("glitch_fe", fe_cnt - f0, 0);
        check("glitch_data", u_if.data, 8'hFF);

        // Bad stop bit followed by a break of five bit times.
        send_frame(8'h3C, BitT, 1'b0);
        #(5 * BitT);
        check("break_busy", u_if.busy, 1'b1);
        check("break_fe", fe_cnt - f0, 1);
        check("break_dv", dv_cnt - b0, 0);
        check("break_data", u_if.data, 8'hFF);
        u_if.rx = 1'b1;
        repeat (2 * Cpb) @(negedge clk);
        check("break_busy_end", u_if.busy, 1'b0);
        send_frame(8'h81, BitT, 1'b1);
        repeat (2 * Cpb) @(negedge clk);
        check("after_break_dv", dv_cnt - b0, 1);
        check("after_break_fe", fe_cnt - f0, 1);
        check("after_break_data", u_if.data, 8'h81);

        // Reset in the middle of bit 4; the partial frame must not be reported.
        b0 = dv_cnt;
        u_if.rx = 1'b0;
        #(BitT);
        for (int i = 0; i < 4; i++) begin
            u_if.rx = a3[i];
            #(BitT);
        end
        check("midframe_busy", u_if.busy, 1'b1);
        u_if.rx = a3[4];
        #(BitT / 2);
        rst_n = 1'b0;
        #1;
        check("rst_data", u_if.data, 8'h00);
        check("rst_dv", u_if.data_valid, 1'b0);
        check("rst_fe", u_if.frame_err, 1'b0);
        check("rst_busy", u_if.busy, 1'b0);
        #(BitT / 2 - 1);
        for (int i = 5; i < 8; i++) begin
            u_if.rx = a3[i];
            #(BitT);
        end
        u_if.rx = 1'b1;
        #(BitT);
        repeat (Cpb) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * Cpb) @(negedge clk);
        send_frame(8'h7E, BitT, 1'b1);
        repeat (2 * Cpb) @(negedge clk);
        check("post_rst_dv", dv_cnt - b0, 1);
        check("post_rst_data", u_if.data, 8'h7E);

        // Random stream: the model is simply the ordered list of well-framed bytes.
        n0     = obs_q.size();
        f0     = fe_cnt;
        fe_exp = 0;
        for (int k = 0; k < 40; k++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                send_frame(rb, bts[$urandom_range(0, 2)], 1'b0);
                u_if.rx = 1'b1;
                fe_exp++;
                repeat ($urandom_range(Cpb, 2 * Cpb)) @(negedge clk);
            end else begin
                send_frame(rb, bts[$urandom_range(0, 2)], 1'b1);
                exp_q.push_back(rb);
                repeat ($urandom_range(0, 2 * Cpb)) @(negedge clk);
            end
        end
        repeat (2 * Cpb) @(negedge clk);
        check("rand_count", obs_q.size() - n0, exp_q.size());
        check("rand_fe", fe_cnt - f0, fe_exp);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (n0 + k < obs_q.size()) check($sformatf("rand_byte%0d", k), obs_q[n0+k], exp_q[k]);
        end

        check("pulse_overlap", overlap_cnt, 0);
        check("pulse_width", wide_cnt, 0);
        check("busy_at_dv", busy_dv_err, 0);
        check("busy_at_fe", busy_fe_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
